// File: rtl/pipeline_ctrl_pkg.sv
// Shared core definitions: controller state encoding, stall/flush bit positions and
// the default data-memory timeout.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StLdBubble = 2'd1,
        StMemWait  = 2'd2,
        StRedirect = 2'd3
    } state_e;

    // Stall vector bit positions (IF..MEM)
    localparam int unsigned StallIf  = 0;
    localparam int unsigned StallId  = 1;
    localparam int unsigned StallEx  = 2;
    localparam int unsigned StallMem = 3;

    // Flush vector bit positions (ID..WB)
    localparam int unsigned FlushId  = 0;
    localparam int unsigned FlushEx  = 1;
    localparam int unsigned FlushMem = 2;
    localparam int unsigned FlushWb  = 3;

    localparam int unsigned DefaultMemTimeout = 255;

endpackage

// File: rtl/pipeline_ctrl_mem_wait_timer.sv
// Saturating 8-bit count of consecutive data-memory wait cycles; flags the cycle in which
// the count has reached the timeout while the wait persists.
module mem_wait_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned Timeout = DefaultMemTimeout
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic wait_en,
    output logic expired
);

    localparam logic [7:0] Limit = Timeout[7:0];

    logic [7:0] count_q, count_d;

    always_comb begin
        expired = wait_en && (count_q == Limit);
        count_d = count_q;
        if (!wait_en || expired) begin
            count_d = 8'd0;
        end else if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: turns hazard, redirect, trap and memory-wait events into
// per-stage stall/flush controls, with a data-memory timeout that raises bus_error_o.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = DefaultMemTimeout
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ld_dependence_i,
    input  logic       branch_taken_i,
    input  logic       exception_i,
    input  logic       imem_ready_i,
    input  logic       dmem_req_i,
    input  logic       dmem_ready_i,
    output logic       if_stall_o,
    output logic       id_stall_o,
    output logic       ex_stall_o,
    output logic       mem_stall_o,
    output logic       id_flush_o,
    output logic       ex_flush_o,
    output logic       mem_flush_o,
    output logic       wb_flush_o,
    output logic       bus_error_o,
    output logic [1:0] state_o
);

    state_e     state_q, state_d;
    logic       bus_error_q;
    logic [3:0] stall, flush;
    logic       data_wait, timer_wait, timer_expired;

    assign data_wait  = dmem_req_i & ~dmem_ready_i;
    assign timer_wait = data_wait & ~exception_i & ~rst_i;

    mem_wait_timer #(
        .Timeout(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk_i),
        .rst    (rst_i),
        .clr    (exception_i),
        .wait_en(timer_wait),
        .expired(timer_expired)
    );

    always_comb begin
        stall   = '0;
        flush   = '0;
        state_d = StRun;
        if (rst_i) begin
            flush = '1;
        end else if (exception_i) begin
            flush   = '1;
            state_d = StRedirect;
        end else if (data_wait) begin
            stall          = '1;
            flush[FlushWb] = 1'b1;
            state_d        = timer_expired ? StRun : StMemWait;
        end else if (branch_taken_i) begin
            flush[FlushId] = 1'b1;
            flush[FlushEx] = 1'b1;
            state_d        = StRedirect;
        end else if (ld_dependence_i && (state_q == StRun || state_q == StMemWait)) begin
            // LD_BUBBLE ignores the flag so one hazard costs exactly one bubble
            stall[StallIf] = 1'b1;
            stall[StallId] = 1'b1;
            flush[FlushEx] = 1'b1;
            state_d        = StLdBubble;
        end else if (!imem_ready_i) begin
            stall[StallIf] = 1'b1;
            flush[FlushId] = 1'b1;
        end else if (state_q == StRedirect) begin
            flush[FlushId] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_error_q <= timer_expired;
        end
    end

    assign if_stall_o  = stall[StallIf];
    assign id_stall_o  = stall[StallId];
    assign ex_stall_o  = stall[StallEx];
    assign mem_stall_o = stall[StallMem];
    assign id_flush_o  = flush[FlushId];
    assign ex_flush_o  = flush[FlushEx];
    assign mem_flush_o = flush[FlushMem];
    assign wb_flush_o  = flush[FlushWb];
    assign bus_error_o = bus_error_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// against a priority-rule reference model.
module tb_pipeline_ctrl;

    localparam int T = 4;

    logic clk, rst, ld, br, exc, im, dreq, drdy;
    logic if_st, id_st, ex_st, mem_st, id_fl, ex_fl, mem_fl, wb_fl, berr;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_state;
    int m_cnt;
    bit m_berr;

    pipeline_ctrl #(
        .MEM_TIMEOUT(T)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ld_dependence_i(ld),
        .branch_taken_i (br),
        .exception_i    (exc),
        .imem_ready_i   (im),
        .dmem_req_i     (dreq),
        .dmem_ready_i   (drdy),
        .if_stall_o     (if_st),
        .id_stall_o     (id_st),
        .ex_stall_o     (ex_st),
        .mem_stall_o    (mem_st),
        .id_flush_o     (id_fl),
        .ex_flush_o     (ex_fl),
        .mem_flush_o    (mem_fl),
        .wb_flush_o     (wb_fl),
        .bus_error_o    (berr),
        .state_o        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] stalls();
        return {mem_st, ex_st, id_st, if_st};
    endfunction

    function automatic logic [3:0] flushes();
        return {wb_fl, mem_fl, ex_fl, id_fl};
    endfunction

    task automatic drive(input logic r, input logic e, input logic b, input logic l,
                         input logic i, input logic q, input logic d);
        rst = r; exc = e; br = b; ld = l; im = i; dreq = q; drdy = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Priority: reset > exception > data wait > branch > load-use (RUN/MEM_WAIT only)
    // > instruction wait > REDIRECT default.
    task automatic model_eval(output logic [3:0] st, output logic [3:0] fl,
                              output int ns, output int nc, output bit nb);
        st = 4'b0000; fl = 4'b0000; ns = 0; nc = 0; nb = 1'b0;
        if (rst) begin
            fl = 4'b1111;
        end else if (exc) begin
            fl = 4'b1111; ns = 3;
        end else if (dreq && !drdy) begin
            st = 4'b1111; fl = 4'b1000;
            if (m_cnt == T) begin
                nb = 1'b1;
            end else begin
                ns = 2;
                nc = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            end
        end else if (br) begin
            fl = 4'b0011; ns = 3;
        end else if (ld && (m_state == 0 || m_state == 2)) begin
            st = 4'b0011; fl = 4'b0010; ns = 1;
        end else if (!im) begin
            st = 4'b0001; fl = 4'b0001;
        end else if (m_state == 3) begin
            fl = 4'b0001;
        end
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        checks++;
        if (stalls() !== 4'b0000) begin
            failures++; $display("FAIL reset_stalls got=%b want=0000", stalls());
        end
        checks++;
        if (flushes() !== 4'b1111) begin
            failures++; $display("FAIL reset_flushes got=%b want=1111", flushes());
        end
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (state !== 2'd0 || berr !== 1'b0 || dut.u_timer.count_q !== 8'd0) begin
            failures++;
            $display("FAIL reset_state got state=%0d berr=%b cnt=%0d want 0/0/0",
                     state, berr, dut.u_timer.count_q);
        end
    endtask

    task automatic test_load_use();
        drive(0, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (stalls() !== 4'b0011 || flushes() !== 4'b0010) begin
            failures++;
            $display("FAIL ld_cycle0 got st=%b fl=%b want st=0011 fl=0010", stalls(), flushes());
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (state !== 2'd1 || stalls() !== 4'b0000) begin
            failures++;
            $display("FAIL ld_cycle1 got state=%0d st=%b want state=1 st=0000", state, stalls());
        end
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (state !== 2'd0) begin
            failures++; $display("FAIL ld_cycle2 got state=%0d want 0", state);
        end
    endtask

    task automatic test_data_wait();
        drive(0, 0, 0, 0, 1, 1, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (stalls() !== 4'b1111 || flushes() !== 4'b1000) begin
                failures++;
                $display("FAIL dwait_c%0d got st=%b fl=%b want st=1111 fl=1000",
                         c, stalls(), flushes());
            end
            next_cycle();
        end
        drive(0, 0, 0, 0, 1, 1, 1);
        @(negedge clk);
        checks++;
        if (stalls() !== 4'b0000 || state !== 2'd2 || dut.u_timer.count_q !== 8'd3) begin
            failures++;
            $display("FAIL dwait_release got st=%b state=%0d cnt=%0d want 0000/2/3",
                     stalls(), state, dut.u_timer.count_q);
        end
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (state !== 2'd0 || dut.u_timer.count_q !== 8'd0) begin
            failures++;
            $display("FAIL dwait_after got state=%0d cnt=%0d want 0/0", state, dut.u_timer.count_q);
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int first = -1;
        logic [1:0] st5 = 2'd3;
        for (int c = 0; c < 11; c++) begin
            if (c < 5) drive(0, 0, 0, 0, 1, 1, 0);
            else       drive(0, 0, 0, 0, 1, 0, 0);
            @(negedge clk);
            if (berr === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (c == 5) st5 = state;
            next_cycle();
        end
        checks++;
        if (pulses != 1 || first != 5) begin
            failures++;
            $display("FAIL timeout_pulse got pulses=%0d at=%0d want 1 at 5", pulses, first);
        end
        checks++;
        if (st5 !== 2'd0) begin
            failures++; $display("FAIL timeout_state got=%0d want 0", st5);
        end
    endtask

    task automatic test_branch_ld();
        drive(0, 0, 1, 1, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (flushes() !== 4'b0011 || stalls() !== 4'b0000) begin
            failures++;
            $display("FAIL br_ld got fl=%b st=%b want fl=0011 st=0000", flushes(), stalls());
        end
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        checks++;
        if (state !== 2'd3 || flushes() !== 4'b0001) begin
            failures++;
            $display("FAIL redirect got state=%0d fl=%b want 3/0001", state, flushes());
        end
        next_cycle();
        // Back into REDIRECT, then a data wait must take precedence over its default
        drive(0, 0, 1, 0, 1, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        checks++;
        if (stalls() !== 4'b1111 || flushes() !== 4'b1000) begin
            failures++;
            $display("FAIL redirect_dwait got st=%b fl=%b want 1111/1000", stalls(), flushes());
        end
        next_cycle();
        checks++;
        if (state !== 2'd2) begin
            failures++; $display("FAIL redirect_dwait_state got=%0d want 2", state);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        next_cycle();
    endtask

    task automatic test_exception_memwait();
        drive(0, 0, 0, 0, 1, 1, 0);
        next_cycle();
        next_cycle();
        drive(0, 1, 0, 0, 1, 1, 0);
        @(negedge clk);
        checks++;
        if (flushes() !== 4'b1111 || stalls() !== 4'b0000) begin
            failures++;
            $display("FAIL exc_memwait got fl=%b st=%b want 1111/0000", flushes(), stalls());
        end
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (state !== 2'd3 || berr !== 1'b0 || dut.u_timer.count_q !== 8'd0) begin
            failures++;
            $display("FAIL exc_next got state=%0d berr=%b cnt=%0d want 3/0/0",
                     state, berr, dut.u_timer.count_q);
        end
        next_cycle();
    endtask

    task automatic test_reset_memwait();
        drive(0, 0, 0, 0, 1, 1, 0);
        next_cycle();
        next_cycle();
        next_cycle();
        drive(1, 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        checks++;
        if (flushes() !== 4'b1111 || stalls() !== 4'b0000) begin
            failures++;
            $display("FAIL rst_memwait got fl=%b st=%b want 1111/0000", flushes(), stalls());
        end
        next_cycle();
        drive(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (state !== 2'd0 || berr !== 1'b0) begin
            failures++;
            $display("FAIL rst_memwait_next got state=%0d berr=%b want 0/0", state, berr);
        end
        @(negedge clk);
        checks++;
        if (berr !== 1'b0) begin
            failures++; $display("FAIL rst_memwait_berr got=%b want 0", berr);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [3:0] est, efl;
        int ns, nc;
        bit nb;
        logic q = 1'b0;
        drive(1, 0, 0, 0, 1, 0, 0);
        next_cycle();
        m_state = 0; m_cnt = 0; m_berr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            q = q ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 3) == 0);
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) != 0), q, ($urandom_range(0, 3) == 0));
            @(negedge clk);
            model_eval(est, efl, ns, nc, nb);
            checks++;
            if (stalls() !== est || flushes() !== efl || state !== m_state[1:0]
                || berr !== m_berr) begin
                failures++;
                $display("FAIL random_c%0d got st=%b fl=%b state=%0d berr=%b want st=%b fl=%b state=%0d berr=%b",
                         c, stalls(), flushes(), state, berr, est, efl, m_state, m_berr);
            end
            next_cycle();
            m_state = ns; m_cnt = nc; m_berr = nb;
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 1, 0, 0);
        next_cycle();
        test_reset();
        test_load_use();
        test_data_wait();
        test_timeout();
        test_branch_ld();
        test_exception_memwait();
        test_reset_memwait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
